// File: rtl/approx_div_pkg.sv
// approx_div_pkg: shared constants and state type for the approximate divider
package approx_div_pkg;
   localparam int unsigned DEFAULT_L = 2;
   localparam int unsigned DIVIDEND_W = 16;
   localparam int unsigned DIVISOR_W = 8;
   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
endpackage

// File: rtl/unsigned_div_step.sv
// unsigned_div_step: one restoring division step, shift in a dividend bit and conditionally subtract
module unsigned_div_step
   import approx_div_pkg::*;
(
   input  logic [DIVISOR_W-1:0] rem,
   input  logic                 bit_in,
   input  logic [DIVISOR_W-1:0] y,
   output logic [DIVISOR_W-1:0] rem_next,
   output logic                 q_bit
);
   logic [DIVISOR_W:0] t;
   logic [DIVISOR_W:0] diff;
   // rem < y before the shift, so t - y always fits back into 8 bits
   always_comb begin
      t = {rem, bit_in};
      diff = t - {1'b0, y};
      q_bit = t >= {1'b0, y};
      rem_next = q_bit ? diff[DIVISOR_W-1:0] : t[DIVISOR_W-1:0];
   end
endmodule

// File: rtl/unsigned_divider_16by8_l2_seq.sv
// unsigned_divider_16by8_l2_seq: sequential 16/8 restoring divider with the low L dividend bits dropped
module unsigned_divider_16by8_l2_seq
   import approx_div_pkg::*;
#(
   parameter int unsigned L = DEFAULT_L
)(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [DIVIDEND_W-1:0] z,
   input  logic [DIVISOR_W-1:0]  y,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DIVISOR_W-1:0]  q,
   output logic [DIVISOR_W-1:0]  r,
   output logic                  ovf,
   output logic                  dz
);
   state_t               state;
   logic [DIVIDEND_W-1:0] zt_in;
   logic [DIVISOR_W-1:0]  zt_lo;
   logic [DIVISOR_W-1:0]  y_q;
   logic [DIVISOR_W-1:0]  rem;
   logic [DIVISOR_W-1:0]  quo;
   logic [2:0]            cnt;
   logic [2:0]            idx;
   logic [DIVISOR_W-1:0]  rem_next;
   logic                  q_bit;
   // mask rather than concatenate so L=0 stays legal
   always_comb begin
      zt_in = z & (16'hFFFF << L);
      idx = ~cnt;
   end
   unsigned_div_step u_step (
      .rem      (rem),
      .bit_in   (zt_lo[idx]),
      .y        (y_q),
      .rem_next (rem_next),
      .q_bit    (q_bit)
   );
   // control FSM with registered handshake and result outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         in_ready <= 1'b1;
         out_valid <= 1'b0;
         q <= '0;
         r <= '0;
         ovf <= 1'b0;
         dz <= 1'b0;
         zt_lo <= '0;
         y_q <= '0;
         rem <= '0;
         quo <= '0;
         cnt <= '0;
      end else begin
         case (state)
            IDLE: if (in_valid) begin
               in_ready <= 1'b0;
               y_q <= y;
               zt_lo <= zt_in[7:0];
               rem <= zt_in[15:8];
               quo <= '0;
               cnt <= '0;
               if (y == '0 || zt_in[15:8] >= y) begin
                  state <= DONE;
                  out_valid <= 1'b1;
                  q <= 8'hFF;
                  r <= 8'h00;
                  dz <= y == '0;
                  ovf <= y != '0;
               end else begin
                  state <= CALC;
               end
            end
            CALC: begin
               rem <= rem_next;
               quo[idx] <= q_bit;
               cnt <= cnt + 3'd1;
               if (cnt == 3'd7) begin
                  state <= DONE;
                  out_valid <= 1'b1;
                  q <= {quo[7:1], q_bit};
                  r <= rem_next;
                  ovf <= 1'b0;
                  dz <= 1'b0;
               end
            end
            DONE: if (out_ready) begin
               state <= IDLE;
               out_valid <= 1'b0;
               in_ready <= 1'b1;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule
